// File: rtl/sp256k_arb_pkg.sv
// Shared constants, port-select encoding, standby FSM states and byte-enable mapping
// for the SP256K dual-requester arbiter.
package sp256k_arb_pkg;

    localparam int AW = 14;
    localparam int DW = 16;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_STDBY  = 2'd1,
        ST_WAKE   = 2'd2
    } arb_state_e;

    // MASKWE works on nibbles, so each byte enable covers two mask bits
    function automatic logic [3:0] be_to_maskwe(input logic [1:0] be);
        return {be[1], be[1], be[0], be[0]};
    endfunction

endpackage

// File: rtl/sp256k_arbiter_idle_ctrl.sv
// Idle counter and standby FSM for the SP256K arbiter; only instantiated when
// SP256K_ARB_STDBY_EN is defined.
module sp256k_idle_ctrl
    import sp256k_arb_pkg::*;
#(
    parameter int IDLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_any_req,
    output logic o_stall,
    output logic o_stdby
);

    arb_state_e r_state;
    logic [7:0] r_idle_cnt;
    logic       r_stall;
    logic       r_stdby;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ACTIVE;
            r_idle_cnt <= 8'd0;
            r_stall    <= 1'b0;
            r_stdby    <= 1'b0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (i_any_req) begin
                        r_idle_cnt <= 8'd0;
                    end else if (r_idle_cnt == 8'(IDLE_CYCLES - 1)) begin
                        r_state    <= ST_STDBY;
                        r_idle_cnt <= 8'd0;
                        r_stall    <= 1'b1;
                        r_stdby    <= 1'b1;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
                end
                ST_STDBY: begin
                    if (i_any_req) begin
                        r_state <= ST_WAKE;
                        r_stdby <= 1'b0;
                    end
                end
                // one recovery cycle with the macro out of standby before granting
                ST_WAKE: begin
                    r_state <= ST_ACTIVE;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= ST_ACTIVE;
                    r_stall <= 1'b0;
                    r_stdby <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall = r_stall;
    assign o_stdby = r_stdby;

endmodule

// File: rtl/sp256k_arbiter.sv
// Two-port (fetch A / load-store B) arbiter in front of one SP256K 16K x 16 SRAM.
// Optional idle standby is enabled by defining SP256K_ARB_STDBY_EN.
module sp256k_arbiter
    import sp256k_arb_pkg::*;
#(
    parameter int FIXED_PRIO  = 0,
    parameter int IDLE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [1:0]    a_be,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [1:0]    b_be,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_ad,
    output logic [DW-1:0] mem_di,
    output logic [3:0]    mem_maskwe,
    output logic          mem_we,
    output logic          mem_cs,
    output logic          mem_stdby,
    output logic          mem_sleep,
    output logic          mem_pwroff_n,
    input  logic [DW-1:0] mem_do
);

    if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_idle_cycles
        $error("IDLE_CYCLES must be within 1..255");
    end

    port_sel_e     r_last;
    port_sel_e     w_sel;
    logic          w_any_req;
    logic          w_stall;
    logic          w_gnt;
    logic [AW-1:0] w_ad;
    logic [DW-1:0] w_di;
    logic [1:0]    w_be;
    logic          w_we;
    logic [AW-1:0] r_ad;
    logic [DW-1:0] r_di;
    logic          r_a_rvalid_p1;
    logic          r_b_rvalid_p1;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;

    assign w_any_req = a_req | b_req;

`ifdef SP256K_ARB_STDBY_EN
    sp256k_idle_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_idle_ctrl (
        .clk      (clk),
        .reset    (reset),
        .i_any_req(w_any_req),
        .o_stall  (w_stall),
        .o_stdby  (mem_stdby)
    );
`else
    assign w_stall   = 1'b0;
    assign mem_stdby = 1'b0;
`endif

    // on a conflict, round-robin hands the slot to whichever port did not win last
    always_comb begin
        w_sel = PORT_A;
        if (a_req && b_req) begin
            if (FIXED_PRIO == 0 && r_last == PORT_A) begin
                w_sel = PORT_B;
            end
        end else if (b_req) begin
            w_sel = PORT_B;
        end
    end

    assign w_gnt = w_any_req & ~w_stall;
    assign a_gnt = w_gnt & (w_sel == PORT_A);
    assign b_gnt = w_gnt & (w_sel == PORT_B);

    assign w_ad = (w_sel == PORT_B) ? b_addr  : a_addr;
    assign w_di = (w_sel == PORT_B) ? b_wdata : a_wdata;
    assign w_be = (w_sel == PORT_B) ? b_be    : a_be;
    assign w_we = (w_sel == PORT_B) ? b_we    : a_we;

    assign mem_cs       = w_gnt;
    assign mem_we       = w_gnt & w_we;
    assign mem_ad       = w_gnt ? w_ad : r_ad;
    assign mem_di       = w_gnt ? w_di : r_di;
    assign mem_maskwe   = w_gnt ? be_to_maskwe(w_be) : 4'b0000;
    assign mem_sleep    = 1'b0;
    assign mem_pwroff_n = 1'b1;

    // p0 -> p1: macro samples the access, read data appears on DO next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last        <= PORT_B;
            r_ad          <= '0;
            r_a_rvalid_p1 <= 1'b0;
            r_b_rvalid_p1 <= 1'b0;
            r_a_rdata     <= '0;
            r_b_rdata     <= '0;
        end else begin
            if (w_gnt) begin
                r_last <= w_sel;
                r_ad   <= w_ad;
            end
            r_a_rvalid_p1 <= a_gnt & ~a_we;
            r_b_rvalid_p1 <= b_gnt & ~b_we;
            if (r_a_rvalid_p1) r_a_rdata <= mem_do;
            if (r_b_rvalid_p1) r_b_rdata <= mem_do;
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt) r_di <= w_di;
    end

    // DO is live during the rvalid cycle; the hold register covers the cycles after
    assign a_rvalid = r_a_rvalid_p1;
    assign b_rvalid = r_b_rvalid_p1;
    assign a_rdata  = r_a_rvalid_p1 ? mem_do : r_a_rdata;
    assign b_rdata  = r_b_rvalid_p1 ? mem_do : r_b_rdata;

endmodule

// File: tb/tb_sp256k_arbiter.sv
// Directed bench for sp256k_arbiter: a round-robin and a fixed-priority instance, each
// backed by a behavioural SP256K model; standby checks run when SP256K_ARB_STDBY_EN is set.
module tb_sp256k_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [13:0] a_addr = '0, b_addr = '0;
    logic [1:0]  a_be = '0, b_be = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;

    logic        a_gnt0, a_rvalid0, b_gnt0, b_rvalid0, mem_we0, mem_cs0, mem_stdby0, mem_sleep0, mem_pwroff_n0;
    logic [15:0] a_rdata0, b_rdata0, mem_di0, mem_do0;
    logic [13:0] mem_ad0;
    logic [3:0]  mem_maskwe0;
    logic        a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, mem_we1, mem_cs1, mem_stdby1, mem_sleep1, mem_pwroff_n1;
    logic [15:0] a_rdata1, b_rdata1, mem_di1, mem_do1;
    logic [13:0] mem_ad1;
    logic [3:0]  mem_maskwe1;

    logic [15:0] mem0 [0:16383];
    logic [15:0] mem1 [0:16383];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sp256k_arbiter #(.FIXED_PRIO(0), .IDLE_CYCLES(4)) u_rr (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_be(a_be), .a_wdata(a_wdata),
        .a_gnt(a_gnt0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_be(b_be), .b_wdata(b_wdata),
        .b_gnt(b_gnt0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
        .mem_ad(mem_ad0), .mem_di(mem_di0), .mem_maskwe(mem_maskwe0), .mem_we(mem_we0),
        .mem_cs(mem_cs0), .mem_stdby(mem_stdby0), .mem_sleep(mem_sleep0),
        .mem_pwroff_n(mem_pwroff_n0), .mem_do(mem_do0)
    );

    sp256k_arbiter #(.FIXED_PRIO(1), .IDLE_CYCLES(4)) u_fp (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_be(a_be), .a_wdata(a_wdata),
        .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_be(b_be), .b_wdata(b_wdata),
        .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
        .mem_ad(mem_ad1), .mem_di(mem_di1), .mem_maskwe(mem_maskwe1), .mem_we(mem_we1),
        .mem_cs(mem_cs1), .mem_stdby(mem_stdby1), .mem_sleep(mem_sleep1),
        .mem_pwroff_n(mem_pwroff_n1), .mem_do(mem_do1)
    );

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] di, input logic [3:0] m);
        logic [15:0] r;
        r = old;
        for (int n = 0; n < 4; n++) if (m[n]) r[n*4 +: 4] = di[n*4 +: 4];
        return r;
    endfunction

    // behavioural SP256K: synchronous access, nibble-masked writes
    always @(posedge clk) begin
        if (mem_cs0) begin
            if (mem_we0) mem0[mem_ad0] <= merge(mem0[mem_ad0], mem_di0, mem_maskwe0);
            else mem_do0 <= mem0[mem_ad0];
        end
        if (mem_cs1) begin
            if (mem_we1) mem1[mem_ad1] <= merge(mem1[mem_ad1], mem_di1, mem_maskwe1);
            else mem_do1 <= mem1[mem_ad1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic ar; logic [13:0] aa; logic aw; logic [1:0] abe; logic [15:0] ad;
        logic br; logic [13:0] ba; logic bw; logic [1:0] bbe; logic [15:0] bd;
        logic eag; logic ebg; logic eav; logic [15:0] eard; logic ebv; logic [15:0] ebrd;
        logic [3:0] emask; logic ecs; logic ewe; logic [13:0] ead;
    } vec_t;

    vec_t vt [16];

    task automatic set_a(input logic r, input logic [13:0] ad, input logic w, input logic [1:0] be, input logic [15:0] d);
        a_req = r; a_addr = ad; a_we = w; a_be = be; a_wdata = d;
    endtask

    task automatic set_b(input logic r, input logic [13:0] ad, input logic w, input logic [1:0] be, input logic [15:0] d);
        b_req = r; b_addr = ad; b_we = w; b_be = be; b_wdata = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_a(1'b0, 14'h0, 1'b0, 2'b00, 16'h0);
        set_b(1'b0, 14'h0, 1'b0, 2'b00, 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem0[16'h0020] = 16'hFFFF; mem1[16'h0020] = 16'hFFFF;
        mem0[16'h0030] = 16'hAAAA; mem1[16'h0030] = 16'hAAAA;
        mem0[16'h0031] = 16'h5555; mem1[16'h0031] = 16'h5555;

        // ar aa aw abe ad | br ba bw bbe bd | eag ebg eav eard ebv ebrd emask ecs ewe ead
        vt[0]  = '{1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,4'h0,1'b0,1'b0,14'h00};
        vt[1]  = '{1'b1,14'h10,1'b1,2'b11,16'hBEEF, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000,4'hF,1'b1,1'b1,14'h10};
        vt[2]  = '{1'b1,14'h10,1'b0,2'b11,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000,4'hF,1'b1,1'b0,14'h10};
        vt[3]  = '{1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,1'b0,1'b1,16'hBEEF,1'b0,16'h0000,4'h0,1'b0,1'b0,14'h10};
        vt[4]  = '{1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b1,14'h20,1'b1,2'b01,16'h1234, 1'b0,1'b1,1'b0,16'hBEEF,1'b0,16'h0000,4'h3,1'b1,1'b1,14'h20};
        vt[5]  = '{1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b1,14'h20,1'b0,2'b11,16'h0000, 1'b0,1'b1,1'b0,16'hBEEF,1'b0,16'h0000,4'hF,1'b1,1'b0,14'h20};
        vt[6]  = '{1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,1'b0,1'b0,16'hBEEF,1'b1,16'hFF34,4'h0,1'b0,1'b0,14'h20};
        vt[7]  = '{1'b1,14'h30,1'b0,2'b11,16'h0000, 1'b1,14'h31,1'b0,2'b11,16'h0000, 1'b1,1'b0,1'b0,16'hBEEF,1'b0,16'hFF34,4'hF,1'b1,1'b0,14'h30};
        vt[8]  = '{1'b1,14'h30,1'b0,2'b11,16'h0000, 1'b1,14'h31,1'b0,2'b11,16'h0000, 1'b0,1'b1,1'b1,16'hAAAA,1'b0,16'hFF34,4'hF,1'b1,1'b0,14'h31};
        vt[9]  = '{1'b1,14'h30,1'b0,2'b11,16'h0000, 1'b1,14'h31,1'b0,2'b11,16'h0000, 1'b1,1'b0,1'b0,16'hAAAA,1'b1,16'h5555,4'hF,1'b1,1'b0,14'h30};
        vt[10] = '{1'b1,14'h30,1'b0,2'b11,16'h0000, 1'b1,14'h31,1'b0,2'b11,16'h0000, 1'b0,1'b1,1'b1,16'hAAAA,1'b0,16'h5555,4'hF,1'b1,1'b0,14'h31};
        vt[11] = '{1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,1'b0,1'b0,16'hAAAA,1'b1,16'h5555,4'h0,1'b0,1'b0,14'h31};
        vt[12] = '{1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,1'b0,1'b0,16'hAAAA,1'b0,16'h5555,4'h0,1'b0,1'b0,14'h31};
        vt[13] = '{1'b1,14'h10,1'b1,2'b00,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b1,1'b0,1'b0,16'hAAAA,1'b0,16'h5555,4'h0,1'b1,1'b1,14'h10};
        vt[14] = '{1'b1,14'h10,1'b0,2'b11,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b1,1'b0,1'b0,16'hAAAA,1'b0,16'h5555,4'hF,1'b1,1'b0,14'h10};
        vt[15] = '{1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,14'h00,1'b0,2'b00,16'h0000, 1'b0,1'b0,1'b1,16'hBEEF,1'b0,16'h5555,4'h0,1'b0,1'b0,14'h10};

        do_reset();
        #2;
        chk("rst a_gnt", a_gnt0, 0);
        chk("rst b_gnt", b_gnt0, 0);
        chk("rst a_rvalid", a_rvalid0, 0);
        chk("rst b_rvalid", b_rvalid0, 0);
        chk("rst a_rdata", a_rdata0, 0);
        chk("rst b_rdata", b_rdata0, 0);
        chk("rst mem_cs", mem_cs0, 0);
        chk("rst mem_we", mem_we0, 0);
        chk("rst mem_stdby", mem_stdby0, 0);
        chk("rst mem_sleep", mem_sleep0, 0);
        chk("rst mem_pwroff_n", mem_pwroff_n0, 1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_a(vt[i].ar, vt[i].aa, vt[i].aw, vt[i].abe, vt[i].ad);
            set_b(vt[i].br, vt[i].ba, vt[i].bw, vt[i].bbe, vt[i].bd);
            #2;
            chk($sformatf("v%0d a_gnt", i), a_gnt0, vt[i].eag);
            chk($sformatf("v%0d b_gnt", i), b_gnt0, vt[i].ebg);
            chk($sformatf("v%0d a_rvalid", i), a_rvalid0, vt[i].eav);
            chk($sformatf("v%0d a_rdata", i), a_rdata0, vt[i].eard);
            chk($sformatf("v%0d b_rvalid", i), b_rvalid0, vt[i].ebv);
            chk($sformatf("v%0d b_rdata", i), b_rdata0, vt[i].ebrd);
            chk($sformatf("v%0d mem_maskwe", i), mem_maskwe0, vt[i].emask);
            chk($sformatf("v%0d mem_cs", i), mem_cs0, vt[i].ecs);
            chk($sformatf("v%0d mem_we", i), mem_we0, vt[i].ewe);
            chk($sformatf("v%0d mem_ad", i), mem_ad0, vt[i].ead);
        end

        // fixed priority: A holds the macro until it lets go, then B in that same cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_a(1'b1, 14'h30, 1'b0, 2'b11, 16'h0);
            set_b(1'b1, 14'h31, 1'b0, 2'b11, 16'h0);
            #2;
            chk($sformatf("fp%0d a_gnt", i), a_gnt1, 1);
            chk($sformatf("fp%0d b_gnt", i), b_gnt1, 0);
            if (i > 0) chk($sformatf("fp%0d a_rdata", i), a_rdata1, 16'hAAAA);
        end
        @(negedge clk);
        set_a(1'b0, 14'h0, 1'b0, 2'b00, 16'h0);
        #2;
        chk("fp3 a_gnt", a_gnt1, 0);
        chk("fp3 b_gnt", b_gnt1, 1);
        @(negedge clk);
        set_b(1'b0, 14'h0, 1'b0, 2'b00, 16'h0);
        #2;
        chk("fp4 b_rvalid", b_rvalid1, 1);
        chk("fp4 b_rdata", b_rdata1, 16'h5555);
        chk("fp4 a_rvalid", a_rvalid1, 0);

        // reset lands while a read is in flight
        do_reset();
        @(negedge clk);
        set_a(1'b1, 14'h31, 1'b0, 2'b11, 16'h0);
        #2;
        chk("rr0 a_gnt", a_gnt0, 1);
        @(negedge clk);
        set_a(1'b0, 14'h0, 1'b0, 2'b00, 16'h0);
        reset = 1'b1;
        #2;
        chk("rr1 a_rvalid", a_rvalid0, 1);
        chk("rr1 a_rdata", a_rdata0, 16'h5555);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rr2 a_rvalid", a_rvalid0, 0);
        chk("rr2 a_rdata", a_rdata0, 0);
        chk("rr2 mem_cs", mem_cs0, 0);

`ifdef SP256K_ARB_STDBY_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("sb idle%0d mem_stdby", i), mem_stdby0, 0);
            @(negedge clk);
        end
        set_a(1'b1, 14'h30, 1'b0, 2'b11, 16'h0);
        #2;
        chk("sb req mem_stdby", mem_stdby0, 1);
        chk("sb req a_gnt", a_gnt0, 0);
        @(negedge clk);
        #2;
        chk("sb wake mem_stdby", mem_stdby0, 0);
        chk("sb wake a_gnt", a_gnt0, 0);
        @(negedge clk);
        #2;
        chk("sb active a_gnt", a_gnt0, 1);
        @(negedge clk);
        set_a(1'b0, 14'h0, 1'b0, 2'b00, 16'h0);
        #2;
        chk("sb a_rvalid", a_rvalid0, 1);
        chk("sb a_rdata", a_rdata0, 16'hAAAA);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sp256k_arbiter.md
Name: sp256k_arbiter

Overview:
Shares one SP256K single-port 16K x 16 SRAM macro between two requesters: port A (instruction fetch) and port B (data load/store).
- Arbitrates per cycle: round-robin by default, or fixed priority to A.
- Drives the macro's address, data, mask and enable pins.
- Returns read data one cycle after grant.
- Optionally places the macro in standby after a programmable idle period.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between A and B; 1 = A always wins a conflict.
- IDLE_CYCLES, 16: consecutive idle cycles before standby entry (standby feature only); legal range 1..255.

Ports:
- clk  in  1  system clock; shared by the macro's CK.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held until a_gnt.
- a_addr  in  14  port A halfword address.
- a_we  in  1  port A write (1) / read (0).
- a_be  in  2  port A byte enables; [0] = bits 7:0, [1] = bits 15:8.
- a_wdata  in  16  port A write data.
- a_gnt  out  1  port A access accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  16  port A read data.
- b_req, b_addr, b_we, b_be, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- mem_ad  out  14  to macro AD.
- mem_di  out  16  to macro DI.
- mem_maskwe  out  4  to macro MASKWE.
- mem_we  out  1  to macro WE.
- mem_cs  out  1  to macro CS.
- mem_stdby  out  1  to macro STDBY.
- mem_sleep  out  1  to macro SLEEP; tied 0.
- mem_pwroff_n  out  1  to macro PWROFF_N; tied 1.
- mem_do  in  16  from macro DO.

Behaviour:
- Reset values:
  - a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we, mem_cs, mem_stdby = 0.
  - rdata outputs = 0.
  - Round-robin pointer `last` = B, so A wins the first conflict.
  - FSM = ACTIVE; idle counter = 0.
- Grant is combinational from the requests and registered state. At most one grant per cycle.
- Arbitration:
  - Only one requester active: that requester is granted.
  - Both active, FIXED_PRIO=1: A is granted.
  - Both active, FIXED_PRIO=0: the requester not in `last` is granted. `last` updates on every grant.
- During a granted cycle:
  - mem_cs = 1.
  - mem_ad, mem_di and mem_we come from the granted port.
  - mem_maskwe = {be[1], be[1], be[0], be[0]}.
  - be = 0 on a write: CS still asserts, no byte changes, grant still issued.
- No grant: mem_cs = 0, mem_we = 0. mem_ad holds its last value.
- Read latency is 1 cycle:
  - A granted read in cycle N gives <port>_rvalid = 1 in cycle N+1, for one cycle.
  - <port>_rdata is registered from mem_do at N+1 and held until the next rvalid for that port.
  - A granted write produces no rvalid.
- Back-to-back: a new grant is allowed in cycle N+1 while rvalid from N is asserted; throughput is one access per cycle.
- A write followed by a read of the same address in the next cycle returns the new data.
- The losing requester keeps req high. Under round-robin it is guaranteed a grant within 2 cycles.
- A req dropped before gnt is a protocol violation; behaviour is undefined, with no recovery required.
- Reset asserted mid-read: the pending rvalid is cancelled, and all outputs take reset values in the next cycle.

Optional Feature:
- Macro: SP256K_ARB_STDBY_EN.
- Defined:
  - FSM states ACTIVE, STDBY, WAKE.
  - ACTIVE: the idle counter increments on cycles with no req and clears on any req. When it reaches IDLE_CYCLES, go to STDBY with mem_stdby = 1.
  - STDBY: gnt is forced 0. Any req goes to WAKE with mem_stdby = 0.
  - WAKE: lasts 1 cycle with gnt forced 0, then ACTIVE.
  - Wake penalty is 2 cycles from req to gnt.
- Undefined: mem_stdby is tied 0, no FSM exists, and the grant path has no penalty.

Decomposition:
- Package sp256k_arb_pkg holds:
  - constants AW = 14, DW = 16;
  - port-select encoding (PORT_A = 0, PORT_B = 1);
  - FSM state enum;
  - a function mapping be[1:0] to MASKWE[3:0].
- Sub-module sp256k_idle_ctrl holds the idle counter and standby FSM. It outputs stall and mem_stdby, and is instantiated only under SP256K_ARB_STDBY_EN.

Test Plan:
- A writes 0xBEEF to 0x0010 with be=11, then reads 0x0010 → a_gnt in both cycles; a_rvalid one cycle after the read grant with a_rdata = 0xBEEF.
- B writes 0x1234 to 0x0020 with be=01 over existing 0xFFFF, then reads → b_rdata = 0xFF34, and mem_maskwe = 0011 during the write.
- A and B both request reads continuously with FIXED_PRIO=0 → grants alternate A, B, A, B; each rvalid arrives on the correct port with the correct data.
- Same stimulus with FIXED_PRIO=1 → A granted every cycle, b_gnt stays 0 until A drops req; B is then granted in that same cycle.
- Reset asserted in the cycle after A's read grant → a_rvalid = 0 next cycle, a_rdata = 0.
- With SP256K_ARB_STDBY_EN and IDLE_CYCLES=4:
  - 4 idle cycles → mem_stdby = 1;
  - A req → mem_stdby = 0 the next cycle;
  - a_gnt arrives exactly 2 cycles after req rises, and the read data is correct.
